// File: rtl/ntt_pkg.sv
// ntt_pkg
//   Definitions shared by the NTT streaming front/back end and the NTT
//   controller: the I/O sequencer state type, the transform-direction
//   encoding and the default polynomial geometry.
package ntt_pkg;

  // Default geometry, kept identical to the controller's defaults.
  localparam int NTT_N          = 4;
  localparam int NTT_DATA_WIDTH = 12;

  // Transform direction as seen on ntt_mode.
  localparam logic NTT_MODE_FWD = 1'b0;
  localparam logic NTT_MODE_INV = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    UNLOAD
  } io_state_t;

endpackage

// File: rtl/ntt_out_fifo.sv
// ntt_out_fifo
//   Two-entry FIFO used as the skid buffer between the 1-cycle BRAM read path
//   and the backpressured output stream. Each entry carries a coefficient and
//   its end-of-frame flag.
// Ports
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   push/din : write one entry (ignored when full and not popping)
//   pop      : remove the head entry (ignored when empty)
//   dout     : head entry, valid while count != 0
//   count    : current occupancy, 0..2
module ntt_out_fifo #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_reg != 2'd0);
  // A full FIFO still accepts a push in the same cycle its head leaves.
  assign do_push = push && ((count_reg != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= din;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/ntt_stream_io.sv
// ntt_stream_io
//   Streaming front/back end for the NTT controller. Loads N coefficients from
//   a valid/ready input stream into BRAM bank 0 (port A), pulses the controller
//   start, waits for completion, then streams the N results out of the bank the
//   controller reports, honouring output backpressure.
// Ports
//   clk, rst                 : clock (rising edge), asynchronous active-high reset
//   s_data/s_valid/s_ready   : input coefficient stream
//   op_mode                  : 0 NTT / 1 INTT, captured on the first input beat
//   result_bank              : bank holding the result, captured in START
//   m_data/m_valid/m_ready   : output coefficient stream, m_last on beat N-1
//   ntt_enable/ntt_mode      : one-cycle start pulse and direction to controller
//   ntt_done                 : controller completion
//   bram_owner               : 1 while this block drives port A of both banks
//   bram_addr/bram0_we/bram_din : port-A address, bank-0 write enable, data
//   bram0_dout/bram1_dout    : port-A read data, one cycle after the address
//   busy                     : high outside IDLE
module ntt_stream_io
  import ntt_pkg::*;
#(
  parameter int N          = NTT_N,
  parameter int ADDR_WIDTH = $clog2(N),
  parameter int DATA_WIDTH = NTT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  op_mode,
  input  logic                  result_bank,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  ntt_enable,
  output logic                  ntt_mode,
  input  logic                  ntt_done,
  output logic                  bram_owner,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram0_we,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram0_dout,
  input  logic [DATA_WIDTH-1:0] bram1_dout,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH:0]   RD_TOTAL  = (ADDR_WIDTH + 1)'(N);

  io_state_t             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] wr_addr_reg;        // load address, wraps modulo N
  logic [ADDR_WIDTH:0]   rd_cnt_reg;         // reads issued; one extra bit so N is reachable
  logic                  mode_reg;
  logic                  bank_reg;
  logic                  inflight_reg;       // a read was issued last cycle
  logic                  inflight_last_reg;  // ... and it was address N-1
  logic                  s_fire;
  logic                  m_fire;
  logic                  rd_issue;
  logic [2:0]            credit_used;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH:0]   fifo_din;
  logic [DATA_WIDTH:0]   fifo_dout;

  assign s_ready = (state_reg == IDLE) || (state_reg == LOAD);
  assign s_fire  = s_valid && s_ready && !rst;
  assign m_fire  = m_valid && m_ready;
  assign busy    = (state_reg != IDLE);

  // Slots already claimed in the FIFO: entries held plus the read in flight,
  // minus the head leaving this cycle. Issuing only while this is below 2
  // keeps the FIFO from overflowing for any m_ready pattern, while still
  // sustaining one beat per clock when m_ready stays high.
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, m_fire};
  assign rd_issue    = (state_reg == UNLOAD) && (rd_cnt_reg != RD_TOTAL) &&
                       (credit_used < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      wr_addr_reg       <= '0;
      rd_cnt_reg        <= '0;
      mode_reg          <= NTT_MODE_FWD;
      bank_reg          <= 1'b0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      inflight_reg      <= rd_issue;
      inflight_last_reg <= rd_issue && (rd_cnt_reg[ADDR_WIDTH-1:0] == ADDR_LAST);
      if (s_fire) begin
        wr_addr_reg <= wr_addr_reg + ADDR_WIDTH'(1);
      end
      if ((state_reg == IDLE) && s_fire) begin
        mode_reg <= op_mode;
      end
      if (state_reg == START) begin
        bank_reg <= result_bank;
      end
      if (rd_issue) begin
        rd_cnt_reg <= rd_cnt_reg + (ADDR_WIDTH + 1)'(1);
      end else if (state_reg != UNLOAD) begin
        rd_cnt_reg <= '0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ntt_enable = 1'b0;
    ntt_mode   = NTT_MODE_FWD;
    bram_owner = 1'b1;
    bram0_we   = 1'b0;
    bram_addr  = '0;
    bram_din   = '0;
    case (state_reg)
      IDLE: begin
        if (s_fire) begin
          bram0_we   = 1'b1;
          bram_addr  = wr_addr_reg;
          bram_din   = s_data;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (s_fire) begin
          bram0_we  = 1'b1;
          bram_addr = wr_addr_reg;
          bram_din  = s_data;
          if (wr_addr_reg == ADDR_LAST) begin
            state_next = START;
          end
        end
      end
      START: begin
        // ntt_done is deliberately not looked at here.
        ntt_enable = 1'b1;
        ntt_mode   = mode_reg;
        bram_owner = 1'b0;
        state_next = RUN;
      end
      RUN: begin
        bram_owner = 1'b0;
        if (ntt_done) begin
          state_next = UNLOAD;
        end
      end
      UNLOAD: begin
        bram_addr = rd_cnt_reg[ADDR_WIDTH-1:0];
        if (m_fire && fifo_dout[DATA_WIDTH]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fifo_din = {inflight_last_reg, bank_reg ? bram1_dout : bram0_dout};

  ntt_out_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_out_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_reg),
    .din  (fifo_din),
    .pop  (m_fire),
    .dout (fifo_dout),
    .count(fifo_count)
  );

  assign m_valid = (fifo_count != 2'd0);
  assign m_data  = fifo_dout[DATA_WIDTH-1:0];
  assign m_last  = m_valid && fifo_dout[DATA_WIDTH];

endmodule
